// File: rtl/dr32e_if_id_stage.sv
// IF->ID stage register for dr32e: main stage register M backed by a one-entry skid S,
// so fetch_ready_o depends only on registered state. Branch/flush discards both entries.
module dr32e_if_id_stage #(
   parameter logic [31:0] ResetInstr = 32'h0000_0013,
   parameter logic [31:0] ResetPc    = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_rdata_i,
   input  logic [31:0] fetch_pc_i,
   input  logic        fetch_is_compressed_i,
   input  logic        fetch_illegal_c_i,
   input  logic        branch_taken_i,
   input  logic        flush_i,
   input  logic        id_done_i,
   output logic        instr_valid_o,
   output logic        instr_first_cycle_o,
   output logic [31:0] instr_rdata_o,
   output logic [31:0] instr_rdata_alu_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_is_compressed_o,
   output logic        illegal_c_insn_o
);

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] rdata_alu;
      logic [31:0] pc;
      logic        is_c;
      logic        ill_c;
   } ifid_pld_t;

   localparam ifid_pld_t RstPld = '{
      rdata:     ResetInstr,
      rdata_alu: ResetInstr,
      pc:        ResetPc,
      is_c:      1'b0,
      ill_c:     1'b0
   };

   logic      m_valid, s_valid, first_q;
   ifid_pld_t m_q, s_q, in_pld;
   logic      flush, accept, m_free;

   // rdata_alu is captured from the same source into its own flops to split decoder/ALU fan-out
   assign in_pld = '{
      rdata:     fetch_rdata_i,
      rdata_alu: fetch_rdata_i,
      pc:        fetch_pc_i,
      is_c:      fetch_is_compressed_i,
      ill_c:     fetch_illegal_c_i
   };

   assign flush         = branch_taken_i | flush_i;
   assign fetch_ready_o = ~s_valid;
   assign accept        = fetch_valid_i & fetch_ready_o & ~flush;
   assign m_free        = ~m_valid | id_done_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         first_q <= 1'b0;
         m_q     <= RstPld;
         s_q     <= RstPld;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         first_q <= 1'b0;
      end else if (m_free && s_valid) begin
         // skid drains first so it is never overtaken by a newer fetch
         m_q     <= s_q;
         m_valid <= 1'b1;
         s_valid <= 1'b0;
         first_q <= 1'b1;
      end else if (m_free && accept) begin
         m_q     <= in_pld;
         m_valid <= 1'b1;
         first_q <= 1'b1;
      end else if (m_free) begin
         m_valid <= 1'b0;
         first_q <= 1'b0;
      end else if (accept) begin
         s_q     <= in_pld;
         s_valid <= 1'b1;
         first_q <= 1'b0;
      end else begin
         first_q <= 1'b0;
      end
   end

   assign instr_valid_o         = m_valid;
   assign instr_first_cycle_o   = m_valid & first_q;
   assign instr_rdata_o         = m_q.rdata;
   assign instr_rdata_alu_o     = m_q.rdata_alu;
   assign instr_pc_o            = m_q.pc;
   assign instr_is_compressed_o = m_q.is_c;
   assign illegal_c_insn_o      = m_valid & m_q.ill_c;

endmodule
